dem_element_decoder: RTL and testbench
======================================

# dem_element_decoder

Receive-side checker for the DEM DAC switching tree. It takes the unit-element enable vector produced by the switching network, reconstructs the digital code by population count, and compares it against the time-aligned quantized code that entered the tree. It also accumulates per-element usage over a fixed window to report mismatch-shaping spread. It sits after the switching tree, in parallel with the analog element drivers, as an on-chip integrity and statistics monitor.

## Interface
- WIDTH, 5: code width; also width of `code_o` and `ref_code_i`.
- N_ELEM, 16: number of unit elements. Legal codes are 0..N_ELEM, and N_ELEM ≤ 2**WIDTH-1.
- TREE_LAT, 2: switching-tree latency in cycles between `ref_code_i` and the matching `elem_i`. Legal range 0..8.
- WINDOW, 256: number of valid samples per usage-statistics window, ≥ 2.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  `elem_i` carries a sample this cycle.
- `elem_i`  in  N_ELEM  unit-element enables from the switching tree.
- `ref_code_i`  in  WIDTH  quantized code at tree input, unconditionally delayed TREE_LAT cycles internally.
- `clear_i`  in  1  synchronous clear of statistics and error state.
- `valid_o`  out  1  `code_o` and `mismatch_o` are valid.
- `code_o`  out  WIDTH  popcount of `elem_i`.
- `mismatch_o`  out  1  one-cycle pulse when `code_o` ≠ delayed reference.
- `err_sticky_o`  out  1  set on any mismatch; cleared only by reset or `clear_i`.
- `err_cnt_o`  out  16  mismatch count, saturating at 16'hFFFF.
- `spread_o`  out  $clog2(WINDOW+1)  max minus min element usage over the last completed window.
- `spread_valid_o`  out  1  one-cycle pulse when `spread_o` updates.

## Operation
- **Reference delay line:** TREE_LAT registers, shifted every cycle regardless of `valid_i`. TREE_LAT = 0 means a direct path.
- **Stage 1:** registers popcount(`elem_i`), the delayed reference, and `valid_i`.
- **Stage 2:** registers `code_o` and `valid_o`. Sets `mismatch_o` = stage-1 valid && (popcount ≠ reference).
  - A reference greater than N_ELEM always mismatches.
  - When the sample is invalid, `mismatch_o` = 0 and `code_o` holds its last value.
- **Error state:** each `mismatch_o` pulse increments `err_cnt_o` (saturating) and sets `err_sticky_o`.
- **Usage tracking:**
  - Per-element counters of width $clog2(WINDOW+1) increment when `valid_i` && `elem_i[k]`.
  - A sample counter counts `valid_i`.
  - On the valid sample that makes the count equal WINDOW, the window closes. Its final counts, including that sample, are used to compute max−min. The result is registered into `spread_o` with a `spread_valid_o` pulse.
  - All usage and sample counters restart at 0 on the next cycle.
- **`clear_i`:**
  - Zeros usage counters, sample counter, `err_cnt_o`, and `err_sticky_o`.
  - Does not flush the pipeline or the delay line.
  - Clear has priority over everything else in the same cycle:
    - a valid sample in that cycle is not counted in the statistics;
    - a `mismatch_o` pulse in that cycle still appears at the output but is not counted;
    - a window close in that cycle is cancelled, and no `spread_valid_o` pulse follows.
  - `spread_o` retains its last value.

## Timing
- **Reset:** all outputs, pipeline registers, delay line and counters are 0 while `reset_i` = 0, applied asynchronously. Release is synchronous to `clk_i`.
- **Pipeline latency:** `valid_i` → `valid_o` is 2 cycles. `ref_code_i` → compare is TREE_LAT + 2 cycles. Throughput is one sample per cycle with no back-pressure.
- **Spread latency:** `spread_valid_o` asserts 1 cycle after the window-closing sample.
- **Reset mid-operation:** in-flight samples are discarded. No `valid_o` appears after release until new `valid_i` input plus 2 cycles.
- **Idle cycles:** back-to-back and gapped `valid_i` are both legal. Gaps do not advance the window.

## Structure
- **Package `dem_pkg`:** holds the default WIDTH and N_ELEM (shared with SwitchingBlock), a popcount function, and the error counter width constant (16).
- **Sub-module `dem_usage_tracker`:** contains the per-element counters, window counter, max/min reduction, and spread register.
- **Top level:** contains the delay line, the two pipeline stages, and the error counter.

## Test plan
- **Reset:** hold `reset_i` = 0 with `valid_i` = 1 → all outputs stay 0. Release with `valid_i` = 0 → `valid_o` stays 0.
- **Match:**
  - TREE_LAT = 2; `ref_code_i` = 3 at cycle t; `elem_i` = 16'h0007 with `valid_i` at t+2.
  - Expect `valid_o` at t+4 with `code_o` = 3 and `mismatch_o` = 0.
- **Mismatch:** reference 5 with `elem_i` = 16'h0003 → `code_o` = 2, `mismatch_o` pulse, `err_cnt_o` = 1, `err_sticky_o` = 1. Then `clear_i` → both return to 0.
- **Boundary codes:**
  - reference 16 with `elem_i` = 16'hFFFF → no mismatch;
  - reference 17 with 16'hFFFF → mismatch;
  - reference 0 with 16'h0000 → no mismatch.
  - Force 65 536 mismatches → `err_cnt_o` holds 16'hFFFF.
- **Window:** WINDOW = 4; four valid samples of `elem_i` = 16'h0001 → one `spread_valid_o` pulse with `spread_o` = 4. Four samples of 16'hFFFF → `spread_o` = 0.
- **Simultaneous events:**
  - `clear_i` on the window-closing sample → no `spread_valid_o`.
  - `reset_i` low mid-stream with samples in flight → outputs 0 at once, and no stale `valid_o` after release.

Source files
------------

// File: rtl/dem_element_decoder_pkg.sv
// Shared DEM constants and helpers, used by the element decoder and the switching tree.
package dem_pkg;

  localparam int DEM_WIDTH  = 5;
  localparam int DEM_N_ELEM = 16;
  localparam int ERR_CNT_W  = 16;
  localparam int POP_MAX    = 256;

  // Callers zero-extend their element vector to POP_MAX bits before counting.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (vec[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dem_element_decoder_usage_tracker.sv
// Per-element usage counters over a fixed window of valid samples; reports max-min spread.
module dem_usage_tracker #(
  parameter int N_ELEM = 16,
  parameter int WINDOW = 256
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  input  logic [N_ELEM-1:0]            elem_i,
  input  logic                         clear_i,
  output logic [$clog2(WINDOW+1)-1:0]  spread_o,
  output logic                         spread_valid_o
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  logic [CNT_W-1:0] use_q    [N_ELEM];
  logic [CNT_W-1:0] use_next [N_ELEM];
  logic [CNT_W-1:0] sample_q;
  logic [CNT_W-1:0] max_v;
  logic [CNT_W-1:0] min_v;
  logic             close_w;

  // A clear in the closing cycle cancels the window close.
  assign close_w = valid_i && !clear_i && (sample_q == CNT_W'(WINDOW - 1));

  // Spread is taken over the counts that include the current sample.
  always_comb begin
    max_v = '0;
    min_v = '1;
    for (int k = 0; k < N_ELEM; k++) begin
      use_next[k] = use_q[k] + CNT_W'(elem_i[k]);
      if (use_next[k] > max_v) max_v = use_next[k];
      if (use_next[k] < min_v) min_v = use_next[k];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < N_ELEM; k++) use_q[k] <= '0;
      sample_q <= '0;
    end else if (clear_i || close_w) begin
      for (int k = 0; k < N_ELEM; k++) use_q[k] <= '0;
      sample_q <= '0;
    end else if (valid_i) begin
      for (int k = 0; k < N_ELEM; k++) use_q[k] <= use_next[k];
      sample_q <= sample_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      spread_o       <= '0;
      spread_valid_o <= 1'b0;
    end else begin
      spread_valid_o <= close_w;
      if (close_w) spread_o <= max_v - min_v;
    end
  end

endmodule

// File: rtl/dem_element_decoder.sv
// Receive-side DEM checker: popcounts the element vector, compares it with the delayed
// reference code, counts mismatches and tracks element-usage spread.
module dem_element_decoder
  import dem_pkg::*;
#(
  parameter int WIDTH    = DEM_WIDTH,
  parameter int N_ELEM   = DEM_N_ELEM,
  parameter int TREE_LAT = 2,
  parameter int WINDOW   = 256
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  input  logic [N_ELEM-1:0]            elem_i,
  input  logic [WIDTH-1:0]             ref_code_i,
  input  logic                         clear_i,
  output logic                         valid_o,
  output logic [WIDTH-1:0]             code_o,
  output logic                         mismatch_o,
  output logic                         err_sticky_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o,
  output logic [$clog2(WINDOW+1)-1:0]  spread_o,
  output logic                         spread_valid_o
);

  logic [WIDTH-1:0]   ref_dly;
  logic [POP_MAX-1:0] elem_ext;
  logic [WIDTH-1:0]   pop_code;
  logic               s1_valid;
  logic [WIDTH-1:0]   s1_pop;
  logic [WIDTH-1:0]   s1_ref;

  // The reference shifts every cycle so it stays aligned with the tree regardless of valid.
  if (TREE_LAT == 0) begin : g_no_dly
    assign ref_dly = ref_code_i;
  end else begin : g_dly
    logic [WIDTH-1:0] dly_q [TREE_LAT];

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        for (int i = 0; i < TREE_LAT; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= ref_code_i;
        for (int i = 1; i < TREE_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign ref_dly = dly_q[TREE_LAT-1];
  end

  always_comb begin
    elem_ext               = '0;
    elem_ext[N_ELEM-1:0]   = elem_i;
    pop_code               = WIDTH'(popcount(elem_ext));
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_valid <= 1'b0;
      s1_pop   <= '0;
      s1_ref   <= '0;
    end else begin
      s1_valid <= valid_i;
      s1_pop   <= pop_code;
      s1_ref   <= ref_dly;
    end
  end

  // Popcount never exceeds N_ELEM, so an out-of-range reference mismatches naturally.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_o    <= 1'b0;
      code_o     <= '0;
      mismatch_o <= 1'b0;
    end else begin
      valid_o    <= s1_valid;
      mismatch_o <= s1_valid && (s1_pop != s1_ref);
      if (s1_valid) code_o <= s1_pop;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      err_cnt_o    <= '0;
      err_sticky_o <= 1'b0;
    end else if (clear_i) begin
      err_cnt_o    <= '0;
      err_sticky_o <= 1'b0;
    end else if (mismatch_o) begin
      err_sticky_o <= 1'b1;
      if (err_cnt_o != {ERR_CNT_W{1'b1}}) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end

  dem_usage_tracker #(
    .N_ELEM (N_ELEM),
    .WINDOW (WINDOW)
  ) u_usage (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .valid_i        (valid_i),
    .elem_i         (elem_i),
    .clear_i        (clear_i),
    .spread_o       (spread_o),
    .spread_valid_o (spread_valid_o)
  );

endmodule

// File: tb/tb_dem_element_decoder.sv
// Scoreboard bench for dem_element_decoder with a short window so spread behaviour is visible.
module tb_dem_element_decoder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [15:0] elem_i;
  logic [4:0]  ref_code_i;
  logic        clear_i;
  logic        valid_o;
  logic [4:0]  code_o;
  logic        mismatch_o;
  logic        err_sticky_o;
  logic [15:0] err_cnt_o;
  logic [2:0]  spread_o;
  logic        spread_valid_o;

  typedef struct packed {
    logic        valid;
    logic [15:0] elem;
    logic [4:0]  refc;
    logic        clear;
    logic [4:0]  code;
    logic        mism;
    logic        spr_v;
    logic [2:0]  spr;
  } stim_t;

  typedef struct packed {
    logic [4:0] code;
    logic       mism;
    int         cyc;
  } exp_t;

  typedef struct packed {
    logic [2:0] spr;
    int         cyc;
  } spr_t;

  stim_t stims [$];
  exp_t  exp_q [$];
  spr_t  spr_q [$];
  exp_t  mon_exp;
  spr_t  mon_spr;
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  dem_element_decoder #(
    .WIDTH    (5),
    .N_ELEM   (16),
    .TREE_LAT (2),
    .WINDOW   (4)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .valid_i        (valid_i),
    .elem_i         (elem_i),
    .ref_code_i     (ref_code_i),
    .clear_i        (clear_i),
    .valid_o        (valid_o),
    .code_o         (code_o),
    .mismatch_o     (mismatch_o),
    .err_sticky_o   (err_sticky_o),
    .err_cnt_o      (err_cnt_o),
    .spread_o       (spread_o),
    .spread_valid_o (spread_valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void add_idle(input logic clr);
    stims.push_back('{valid: 1'b0, elem: 16'h0, refc: 5'd0, clear: clr,
                      code: 5'd0, mism: 1'b0, spr_v: 1'b0, spr: 3'd0});
  endfunction

  function automatic void add_sample(input logic [15:0] elem, input logic [4:0] refc,
                                     input logic [4:0] code, input logic mism,
                                     input logic clr = 1'b0, input logic spr_v = 1'b0,
                                     input logic [2:0] spr = 3'd0);
    stims.push_back('{valid: 1'b1, elem: elem, refc: refc, clear: clr,
                      code: code, mism: mism, spr_v: spr_v, spr: spr});
  endfunction

  // Reference for entry i is driven two cycles early to match the tree latency.
  task automatic applyStimulus();
    for (int i = 0; i < stims.size(); i++) begin
      valid_i    = stims[i].valid;
      elem_i     = stims[i].elem;
      clear_i    = stims[i].clear;
      ref_code_i = (i + 2 < stims.size()) ? stims[i+2].refc : 5'd0;
      if (stims[i].valid) exp_q.push_back('{code: stims[i].code, mism: stims[i].mism, cyc: cyc + 2});
      if (stims[i].spr_v) spr_q.push_back('{spr: stims[i].spr, cyc: cyc + 1});
      @(posedge clk_i);
      #1;
    end
    stims.delete();
    valid_i    = 1'b0;
    clear_i    = 1'b0;
    elem_i     = 16'h0;
    ref_code_i = 5'd0;
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_valid_o"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_code_o"}, 32'(code_o), 32'd0);
    checkOutput({tag, "_mismatch_o"}, 32'(mismatch_o), 32'd0);
    checkOutput({tag, "_err_sticky_o"}, 32'(err_sticky_o), 32'd0);
    checkOutput({tag, "_err_cnt_o"}, 32'(err_cnt_o), 32'd0);
    checkOutput({tag, "_spread_o"}, 32'(spread_o), 32'd0);
    checkOutput({tag, "_spread_valid_o"}, 32'(spread_valid_o), 32'd0);
  endtask

  task automatic check_err(input string tag, input logic [15:0] cnt, input logic sticky);
    checkOutput({tag, "_err_cnt_o"}, 32'(err_cnt_o), 32'(cnt));
    checkOutput({tag, "_err_sticky_o"}, 32'(err_sticky_o), 32'(sticky));
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (reset_i) begin
      checkOutput("mismatch_without_valid", 32'(mismatch_o & ~valid_o), 32'd0);
      if (valid_o) begin
        checkOutput("valid_o_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          checkOutput("code_o", 32'(code_o), 32'(mon_exp.code));
          checkOutput("mismatch_o", 32'(mismatch_o), 32'(mon_exp.mism));
          checkOutput("valid_o_latency", 32'(cyc), 32'(mon_exp.cyc));
        end
      end
      if (spread_valid_o) begin
        checkOutput("spread_valid_expected", 32'(spr_q.size() > 0), 32'd1);
        if (spr_q.size() > 0) begin
          mon_spr = spr_q.pop_front();
          checkOutput("spread_o", 32'(spread_o), 32'(mon_spr.spr));
          checkOutput("spread_latency", 32'(cyc), 32'(mon_spr.cyc));
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i    = 1'b0;
    valid_i    = 1'b1;
    elem_i     = 16'hFFFF;
    ref_code_i = 5'd3;
    clear_i    = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check_idle("reset_hold");
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    valid_i = 1'b0;
    elem_i  = 16'h0;
    repeat (4) begin
      @(negedge clk_i);
      checkOutput("valid_o_after_release", 32'(valid_o), 32'd0);
    end
    @(posedge clk_i);
    #1;

    add_idle(1'b1); add_idle(1'b0);
    add_sample(16'h0007, 5'd3, 5'd3, 1'b0);
    repeat (3) add_idle(1'b0);
    applyStimulus();
    check_err("match", 16'd0, 1'b0);

    add_idle(1'b1); add_idle(1'b0);
    add_sample(16'h0003, 5'd5, 5'd2, 1'b1);
    repeat (3) add_idle(1'b0);
    applyStimulus();
    check_err("mismatch", 16'd1, 1'b1);
    add_idle(1'b1);
    applyStimulus();
    check_err("after_clear", 16'd0, 1'b0);

    add_idle(1'b1); add_idle(1'b0);
    add_sample(16'hFFFF, 5'd16, 5'd16, 1'b0);
    add_sample(16'hFFFF, 5'd17, 5'd16, 1'b1);
    add_sample(16'h0000, 5'd0,  5'd0,  1'b0);
    add_sample(16'h0001, 5'd0,  5'd1,  1'b1, 1'b0, 1'b1, 3'd1);
    repeat (3) add_idle(1'b0);
    applyStimulus();
    check_err("boundary", 16'd2, 1'b1);
    add_idle(1'b1);
    applyStimulus();
    checkOutput("spread_held_on_clear", 32'(spread_o), 32'd1);

    add_idle(1'b1); add_idle(1'b0);
    repeat (3) add_sample(16'h0001, 5'd1, 5'd1, 1'b0);
    add_sample(16'h0001, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1, 3'd4);
    repeat (3) add_sample(16'hFFFF, 5'd16, 5'd16, 1'b0);
    add_sample(16'hFFFF, 5'd16, 5'd16, 1'b0, 1'b0, 1'b1, 3'd0);
    repeat (3) add_idle(1'b0);
    applyStimulus();
    check_err("window", 16'd0, 1'b0);

    add_idle(1'b1); add_idle(1'b0);
    repeat (3) add_sample(16'h0001, 5'd1, 5'd1, 1'b0);
    add_sample(16'h0001, 5'd1, 5'd1, 1'b0, 1'b1);
    repeat (3) add_sample(16'h0003, 5'd2, 5'd2, 1'b0);
    add_sample(16'h0003, 5'd2, 5'd2, 1'b0, 1'b0, 1'b1, 3'd4);
    repeat (3) add_idle(1'b0);
    applyStimulus();

    add_idle(1'b1); add_idle(1'b0);
    for (int i = 0; i < 65540; i++)
      add_sample(16'hFFFF, 5'd17, 5'd16, 1'b1, 1'b0, (i % 4) == 3, 3'd0);
    repeat (3) add_idle(1'b0);
    applyStimulus();
    check_err("saturate", 16'hFFFF, 1'b1);

    add_idle(1'b1); add_idle(1'b0);
    repeat (3) add_sample(16'h0005, 5'd3, 5'd2, 1'b1);
    applyStimulus();
    valid_i = 1'b1;
    elem_i  = 16'h0005;
    #1;
    reset_i = 1'b0;
    #1;
    check_idle("reset_midstream");
    exp_q.delete();
    spr_q.delete();
    repeat (2) @(posedge clk_i);
    valid_i = 1'b0;
    elem_i  = 16'h0;
    #1;
    reset_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      checkOutput("no_stale_valid_o", 32'(valid_o), 32'd0);
    end
    @(posedge clk_i);
    #1;

    add_idle(1'b0); add_idle(1'b0);
    add_sample(16'h0003, 5'd2, 5'd2, 1'b0);
    repeat (3) add_idle(1'b0);
    applyStimulus();
    check_err("post_reset", 16'd0, 1'b0);

    checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("spr_q_drained", 32'(spr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
